// File: rtl/seg_display_scan.sv
// Two-digit multiplexed seven-segment driver with per-frame shadow capture.
// Optional lamp test input enabled by defining SEG_LAMP_TEST_EN.
module seg_display_scan #(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] seg0_in,
  input  logic [7:0] seg1_in,
`ifdef SEG_LAMP_TEST_EN
  input  logic       lamp_test,
`endif
  output logic [7:0] seg,
  output logic [3:0] an,
  output logic       frame_tick
);

  typedef enum logic {
    BLANK,
    SHOW
  } state_t;

  localparam logic [15:0] LAST = 16'(REFRESH_DIV - 1);
  localparam logic [15:0] BLAST =
    16'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam bit HAS_BLANK = (BLANK_CYCLES > 0);

  logic [15:0] cnt;
  logic        digit;
  state_t      state;
  logic [7:0]  sh0;
  logic [7:0]  sh1;
  logic        frame0;
  logic        wrap;
  logic        lamp;
  logic [7:0]  pat;

  assign frame0 = !digit && (cnt == '0);
  assign wrap   = (cnt == LAST);

`ifdef SEG_LAMP_TEST_EN
  assign lamp = lamp_test;
`else
  assign lamp = 1'b0;
`endif

  // Bypass the shadow on the capture edge so a zero-blank slot
  // shows the freshly captured digit-0 pattern immediately.
  assign pat = digit ? sh1 : (frame0 ? seg0_in : sh0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt        <= '0;
      digit      <= 1'b0;
      sh0        <= 8'hFF;
      sh1        <= 8'hFF;
      seg        <= 8'hFF;
      an         <= 4'b1111;
      frame_tick <= 1'b0;
      if (HAS_BLANK) state <= BLANK;
      else           state <= SHOW;
    end else begin
      frame_tick <= frame0;
      if (frame0) begin
        sh0 <= seg0_in;
        sh1 <= seg1_in;
      end
      cnt <= wrap ? '0 : cnt + 16'd1;
      if (wrap) digit <= !digit;
      unique case (state)
        BLANK: begin
          an  <= 4'b1111;
          seg <= 8'hFF;
          if (cnt == BLAST) state <= SHOW;
        end
        SHOW: begin
          an  <= digit ? 4'b1101 : 4'b1110;
          seg <= lamp ? 8'h00 : pat;
          if (wrap) begin
            if (HAS_BLANK) state <= BLANK;
            else           state <= SHOW;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg_display_scan.sv
// Bench for seg_display_scan: two instances (blank=2, blank=0) checked
// every cycle against a frame-position model plus pinned literal values.
module tb_seg_display_scan;

  localparam int RD = 8;
  localparam int FR = 2 * RD;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] seg0_in;
  logic [7:0] seg1_in;
  logic       lamp_test = 1'b0;

  logic [7:0] b_seg, n_seg;
  logic [3:0] b_an, n_an;
  logic       b_tick, n_tick;

  int n_cmp = 0;
  int n_bad = 0;

  int t = 0;
  int eidx = -1;
  logic [7:0] cap0 = 8'hFF;
  logic [7:0] cap1 = 8'hFF;
  logic [3:0] eb_an, en_an;
  logic [7:0] eb_seg, en_seg;
  logic       eb_tick, en_tick;

  always #5 clk = ~clk;

  seg_display_scan #(.REFRESH_DIV(RD), .BLANK_CYCLES(2)) u_b (
    .clk(clk),
    .reset(reset),
    .seg0_in(seg0_in),
    .seg1_in(seg1_in),
`ifdef SEG_LAMP_TEST_EN
    .lamp_test(lamp_test),
`endif
    .seg(b_seg),
    .an(b_an),
    .frame_tick(b_tick)
  );

  seg_display_scan #(.REFRESH_DIV(RD), .BLANK_CYCLES(0)) u_n (
    .clk(clk),
    .reset(reset),
    .seg0_in(seg0_in),
    .seg1_in(seg1_in),
`ifdef SEG_LAMP_TEST_EN
    .lamp_test(lamp_test),
`endif
    .seg(n_seg),
    .an(n_an),
    .frame_tick(n_tick)
  );

  task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at t=%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Output after the edge at frame position p, from the slot rules.
  function automatic void model(
    input  int         b,
    input  int         p,
    input  logic [7:0] s0,
    input  logic [7:0] s1,
    input  logic       lp,
    output logic [3:0] a,
    output logic [7:0] s,
    output logic       tk
  );
    int d;
    int c;
    d  = p / RD;
    c  = p % RD;
    tk = (p == 0);
    a  = 4'b1111;
    if (c < b) begin
      s = 8'hFF;
    end else begin
      a[d] = 1'b0;
      s = lp ? 8'h00 : ((d == 0) ? s0 : s1);
    end
  endfunction

  task automatic cycle();
    int p;
    @(posedge clk);
    if (reset) begin
      p = t % FR;
      if (p == 0) begin
        cap0 = seg0_in;
        cap1 = seg1_in;
      end
      model(2, p, cap0, cap1, lamp_test, eb_an, eb_seg, eb_tick);
      model(0, p, cap0, cap1, lamp_test, en_an, en_seg, en_tick);
      eidx = t;
      t++;
    end else begin
      t = 0;
      eidx = -1;
      eb_an = 4'b1111; eb_seg = 8'hFF; eb_tick = 1'b0;
      en_an = 4'b1111; en_seg = 8'hFF; en_tick = 1'b0;
    end
    #1;
    chk("b_an", {4'h0, b_an}, {4'h0, eb_an});
    chk("b_seg", b_seg, eb_seg);
    chk("b_tick", {7'h0, b_tick}, {7'h0, eb_tick});
    chk("n_an", {4'h0, n_an}, {4'h0, en_an});
    chk("n_seg", n_seg, en_seg);
    chk("n_tick", {7'h0, n_tick}, {7'h0, en_tick});
    chk("b_onehot", {7'h0, $countones(~b_an) <= 1}, 8'd1);
    chk("b_an_hi", {6'h0, b_an[3:2]}, 8'd3);
    @(negedge clk);
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    reset   = 1'b0;
    seg0_in = 8'hC0;
    seg1_in = 8'hF9;
    @(negedge clk);
    run(4);
    chk("rst_an", {4'h0, b_an}, 8'h0F);
    chk("rst_seg", b_seg, 8'hFF);

    reset = 1'b1;
    run(1);
    chk("e0_tick", {7'h0, b_tick}, 8'd1);
    chk("e0_b_an", {4'h0, b_an}, 8'h0F);
    chk("e0_n_an", {4'h0, n_an}, 8'h0E);
    chk("e0_n_seg", n_seg, 8'hC0);
    run(2);
    chk("e2_an", {4'h0, b_an}, 8'h0E);
    chk("e2_seg", b_seg, 8'hC0);
    run(8);
    chk("e10_an", {4'h0, b_an}, 8'h0D);
    chk("e10_seg", b_seg, 8'hF9);
    run(6);
    chk("e16_tick", {7'h0, b_tick}, 8'd1);
    run(11);
    seg1_in = 8'hA4;
    run(4);
    chk("e31_seg_hold", b_seg, 8'hF9);
    run(11);
    chk("e42_seg_new", b_seg, 8'hA4);

    reset = 1'b0;
    #1;
    chk("async_an", {4'h0, b_an}, 8'h0F);
    chk("async_seg", b_seg, 8'hFF);
    chk("async_n_an", {4'h0, n_an}, 8'h0F);
    @(negedge clk);
    run(3);
    reset = 1'b1;

    for (int i = 0; i < 1000 * FR; i++) begin
      if ($urandom_range(7) == 0) seg0_in = 8'($urandom);
      if ($urandom_range(7) == 0) seg1_in = 8'($urandom);
`ifdef SEG_LAMP_TEST_EN
      if ($urandom_range(15) == 0) lamp_test = ~lamp_test;
`endif
      if ($urandom_range(2999) == 0) reset = 1'b0;
      else reset = 1'b1;
      cycle();
    end
    reset = 1'b1;

`ifdef SEG_LAMP_TEST_EN
    lamp_test = 1'b1;
    run(FR);
    lamp_test = 1'b0;
    run(FR);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
